aes_key_mem: RTL

- Key-expansion and round-key storage block for the AES core.
- On `init`, it expands a 128- or 256-bit cipher key into 11 or 15 round keys, producing one round key per cycle, and stores them in an internal register file.
- It sits directly upstream of the decipher round: the decipher round drives `round` and consumes `round_key` combinationally.
- SubWord uses an external, shared, combinational 4-byte S-box through the `sboxw`/`new_sboxw` port pair.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_key_mem.sv | 134 +++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round limits, key-memory FSM states,
// and GF(2^8) helpers used by both key expansion and the cipher rounds.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'h0;
    localparam logic       AES_256_BIT_KEY = 1'h1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GENERATE = 2'd1,
        DONE     = 2'd2
    } key_mem_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    // Running XOR of a 4-word key with t folded into word 0 first.
    function automatic logic [127:0] chain_words(input logic [127:0] base,
                                                 input logic [31:0]  t);
        logic [31:0] n0, n1, n2, n3;
        n0 = base[127:96] ^ t;
        n1 = base[95:64]  ^ n0;
        n2 = base[63:32]  ^ n1;
        n3 = base[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_key_mem.sv
// AES key expansion with a 15-entry round-key register file; one round key per cycle,
// combinational read port for the decipher round.
module aes_key_mem
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    key_mem_state_e state_q, state_d;
    logic [3:0]     round_ctr_q, round_ctr_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [255:0]   key_q, key_d;
    logic           keylen_q, keylen_d;
    logic           ready_q, ready_d;
    logic [127:0]   prev_key0_q, prev_key0_d;
    logic [127:0]   prev_key1_q, prev_key1_d;
    logic [127:0]   mem_q [0:14];
    logic [127:0]   mem_d [0:14];

    logic [127:0]   new_key;
    logic [31:0]    rot_word;
    logic [31:0]    t_word;
    logic           rcon_step;
    logic [3:0]     last_round;

    assign sboxw = prev_key0_q[31:0];
    assign ready = ready_q;

    // Next round key from the previous one (AES-128) or the previous two (AES-256).
    always_comb begin
        rot_word   = {new_sboxw[23:0], new_sboxw[31:24]};
        last_round = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
        new_key    = '0;
        t_word     = '0;
        rcon_step  = 1'b0;
        if (round_ctr_q == 4'd0) begin
            new_key = key_q[255:128];
        end else if (keylen_q == AES_256_BIT_KEY && round_ctr_q == 4'd1) begin
            new_key = key_q[127:0];
        end else if (keylen_q == AES_128_BIT_KEY) begin
            t_word    = rot_word ^ {rcon_q, 24'h0};
            new_key   = chain_words(prev_key0_q, t_word);
            rcon_step = 1'b1;
        end else if (!round_ctr_q[0]) begin
            t_word    = rot_word ^ {rcon_q, 24'h0};
            new_key   = chain_words(prev_key1_q, t_word);
            rcon_step = 1'b1;
        end else begin
            t_word  = new_sboxw;
            new_key = chain_words(prev_key1_q, t_word);
        end
    end

    always_comb begin
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        rcon_d      = rcon_q;
        key_d       = key_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        prev_key0_d = prev_key0_q;
        prev_key1_d = prev_key1_q;
        for (int i = 0; i < 15; i++) mem_d[i] = mem_q[i];

        case (state_q)
            IDLE, DONE: begin
                if (init) begin
                    key_d       = key;
                    keylen_d    = keylen;
                    round_ctr_d = 4'd0;
                    rcon_d      = 8'h01;
                    ready_d     = 1'b0;
                    state_d     = GENERATE;
                end
            end
            GENERATE: begin
                for (int i = 0; i < 15; i++) begin
                    if (round_ctr_q == 4'(i)) mem_d[i] = new_key;
                end
                prev_key1_d = prev_key0_q;
                prev_key0_d = new_key;
                round_ctr_d = round_ctr_q + 4'd1;
                if (rcon_step) rcon_d = xtime(rcon_q);
                if (round_ctr_q == last_round) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_ctr_q <= 4'd0;
            rcon_q      <= 8'h01;
            key_q       <= '0;
            keylen_q    <= AES_128_BIT_KEY;
            ready_q     <= 1'b0;
            prev_key0_q <= '0;
            prev_key1_q <= '0;
            for (int i = 0; i < 15; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            rcon_q      <= rcon_d;
            key_q       <= key_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
            prev_key0_q <= prev_key0_d;
            prev_key1_q <= prev_key1_d;
            for (int i = 0; i < 15; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Address 15 has no backing entry and reads as zero.
    always_comb begin
        round_key = '0;
        for (int i = 0; i < 15; i++) begin
            if (round == 4'(i)) round_key = mem_q[i];
        end
    end

endmodule
